// File: rtl/hazard3_ahbl_arb_2to1_if.sv
// AHB-Lite link between one master and one slave. Upstream CPU ports carry no
// burst or lock information, so the slave view leaves hburst/hmastlock out.
interface hazard3_ahbl_arb_2to1_if #(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32
);
  logic [W_ADDR-1:0] haddr;
  logic              hwrite;
  logic [1:0]        htrans;
  logic [2:0]        hsize;
  logic [3:0]        hprot;
  logic              hexcl;
  logic [2:0]        hburst;
  logic              hmastlock;
  logic [W_DATA-1:0] hwdata;
  logic              hready;
  logic              hresp;
  logic              hexokay;
  logic [W_DATA-1:0] hrdata;

  modport master (
    output haddr, hwrite, htrans, hsize, hprot, hexcl, hburst, hmastlock, hwdata,
    input  hready, hresp, hexokay, hrdata
  );

  modport slave (
    input  haddr, hwrite, htrans, hsize, hprot, hexcl, hwdata,
    output hready, hresp, hexokay, hrdata
  );
endinterface

// File: rtl/hazard3_ahbl_arb_2to1.sv
// Fixed-priority (s0 over s1) 2:1 AHB-Lite arbiter. Uncontended requests pass
// straight through; a losing address phase is buffered and replayed later.
//
// Handshake: an upstream request is taken when (htrans & NSEQ) && hready on that
// port; a downstream address phase is taken when m.htrans is NSEQ and m.hready is
// high, after which that source owns the next data phase.
module hazard3_ahbl_arb_2to1 #(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32
) (
  input  logic clk,
  input  logic rst,
  hazard3_ahbl_arb_2to1_if.slave  s0,
  hazard3_ahbl_arb_2to1_if.slave  s1,
  hazard3_ahbl_arb_2to1_if.master m,
  output logic [1:0] dbg_buf_vld,
  output logic [1:0] dbg_dph_own
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_S0   = 2'd1,
    OWN_S1   = 2'd2
  } own_t;

  typedef enum logic [2:0] {
    APH_NONE  = 3'd0,
    APH_LIVE0 = 3'd1,
    APH_LIVE1 = 3'd2,
    APH_BUF0  = 3'd3,
    APH_BUF1  = 3'd4
  } aph_t;

  typedef struct packed {
    logic [W_ADDR-1:0] haddr;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [3:0]        hprot;
    logic              hexcl;
  } req_t;

  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_NSEQ = 2'b10;

  req_t live_req0, live_req1;
  req_t buf_req0, buf_req1;
  req_t m_req;
  logic buf_vld0, buf_vld1;
  own_t dph_own;
  aph_t hold_q;
  aph_t aph_src;
  aph_t cand0, cand1;
  logic live0, live1;

  assign live_req0 = '{haddr: s0.haddr, hwrite: s0.hwrite, hsize: s0.hsize,
                       hprot: s0.hprot, hexcl: s0.hexcl};
  assign live_req1 = '{haddr: s1.haddr, hwrite: s1.hwrite, hsize: s1.hsize,
                       hprot: s1.hprot, hexcl: s1.hexcl};

  // A port with a pending buffer is stalled until the buffer issues and completes.
  assign s0.hready = (dph_own == OWN_S0) ? m.hready : !buf_vld0;
  assign s1.hready = (dph_own == OWN_S1) ? m.hready : !buf_vld1;

  assign live0 = ((s0.htrans & HTRANS_NSEQ) != HTRANS_IDLE) && s0.hready;
  assign live1 = ((s1.htrans & HTRANS_NSEQ) != HTRANS_IDLE) && s1.hready;

  // A buffered request already shown during a stall stays on m until taken.
  always_comb begin
    cand0   = APH_NONE;
    cand1   = APH_NONE;
    aph_src = APH_NONE;
    if (buf_vld0)
      cand0 = APH_BUF0;
    else if (live0 && m.hready)
      cand0 = APH_LIVE0;
    if (buf_vld1)
      cand1 = APH_BUF1;
    else if (live1 && m.hready)
      cand1 = APH_LIVE1;
    if (hold_q != APH_NONE)
      aph_src = hold_q;
    else if (cand0 != APH_NONE)
      aph_src = cand0;
    else
      aph_src = cand1;
  end

  always_comb begin
    m_req = '0;
    case (aph_src)
      APH_LIVE0: m_req = live_req0;
      APH_LIVE1: m_req = live_req1;
      APH_BUF0:  m_req = buf_req0;
      APH_BUF1:  m_req = buf_req1;
      default:   m_req = '0;
    endcase
  end

  assign m.haddr     = m_req.haddr;
  assign m.hwrite    = m_req.hwrite;
  assign m.hsize     = m_req.hsize;
  assign m.hprot     = m_req.hprot;
  assign m.hexcl     = m_req.hexcl;
  assign m.htrans    = (aph_src != APH_NONE) ? HTRANS_NSEQ : HTRANS_IDLE;
  assign m.hburst    = 3'b000;
  assign m.hmastlock = 1'b0;

  assign m.hwdata = (dph_own == OWN_S0) ? s0.hwdata :
                    (dph_own == OWN_S1) ? s1.hwdata : '0;

  assign s0.hrdata  = m.hrdata;
  assign s1.hrdata  = m.hrdata;
  assign s0.hresp   = m.hresp   && (dph_own == OWN_S0);
  assign s1.hresp   = m.hresp   && (dph_own == OWN_S1);
  assign s0.hexokay = m.hexokay && (dph_own == OWN_S0);
  assign s1.hexokay = m.hexokay && (dph_own == OWN_S1);

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_vld0 <= 1'b0;
      buf_vld1 <= 1'b0;
      buf_req0 <= '0;
      buf_req1 <= '0;
      dph_own  <= OWN_NONE;
      hold_q   <= APH_NONE;
    end else begin
      if (live0 && aph_src != APH_LIVE0) begin
        buf_req0 <= live_req0;
        buf_vld0 <= 1'b1;
      end else if (m.hready && aph_src == APH_BUF0) begin
        buf_vld0 <= 1'b0;
      end

      if (live1 && aph_src != APH_LIVE1) begin
        buf_req1 <= live_req1;
        buf_vld1 <= 1'b1;
      end else if (m.hready && aph_src == APH_BUF1) begin
        buf_vld1 <= 1'b0;
      end

      if (m.hready) begin
        hold_q <= APH_NONE;
        case (aph_src)
          APH_LIVE0, APH_BUF0: dph_own <= OWN_S0;
          APH_LIVE1, APH_BUF1: dph_own <= OWN_S1;
          default:             dph_own <= OWN_NONE;
        endcase
      end else begin
        hold_q <= aph_src;
      end
    end
  end

  assign dbg_buf_vld = {buf_vld1, buf_vld0};
  assign dbg_dph_own = dph_own;

endmodule

// File: tb/tb_hazard3_ahbl_arb_2to1.sv
// Directed bench for the 2:1 AHB-Lite arbiter: each task drives one scenario
// cycle by cycle and compares outputs against hand-derived values.
module tb_hazard3_ahbl_arb_2to1;

  localparam int W_ADDR = 32;
  localparam int W_DATA = 32;

  logic clk;
  logic rst;
  logic [1:0] dbg_buf_vld;
  logic [1:0] dbg_dph_own;
  int checks;
  int failures;

  hazard3_ahbl_arb_2to1_if #(.W_ADDR(W_ADDR), .W_DATA(W_DATA)) s0_bus ();
  hazard3_ahbl_arb_2to1_if #(.W_ADDR(W_ADDR), .W_DATA(W_DATA)) s1_bus ();
  hazard3_ahbl_arb_2to1_if #(.W_ADDR(W_ADDR), .W_DATA(W_DATA)) m_bus ();

  hazard3_ahbl_arb_2to1 #(.W_ADDR(W_ADDR), .W_DATA(W_DATA)) dut (
    .clk         (clk),
    .rst         (rst),
    .s0          (s0_bus),
    .s1          (s1_bus),
    .m           (m_bus),
    .dbg_buf_vld (dbg_buf_vld),
    .dbg_dph_own (dbg_dph_own)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic up_idle();
    s0_bus.htrans = 2'b00; s0_bus.haddr = '0; s0_bus.hwrite = 1'b0;
    s0_bus.hsize = 3'd2; s0_bus.hprot = 4'h3; s0_bus.hexcl = 1'b0;
    s1_bus.htrans = 2'b00; s1_bus.haddr = '0; s1_bus.hwrite = 1'b0;
    s1_bus.hsize = 3'd2; s1_bus.hprot = 4'h3; s1_bus.hexcl = 1'b0;
  endtask

  task automatic m_ok();
    m_bus.hready = 1'b1; m_bus.hresp = 1'b0; m_bus.hexokay = 1'b0;
    m_bus.hrdata = '0;
  endtask

  task automatic req0(input logic [31:0] addr, input logic wr, input logic excl);
    s0_bus.htrans = 2'b10; s0_bus.haddr = addr; s0_bus.hwrite = wr; s0_bus.hexcl = excl;
  endtask

  task automatic req1(input logic [31:0] addr);
    s1_bus.htrans = 2'b10; s1_bus.haddr = addr; s1_bus.hwrite = 1'b0; s1_bus.hexcl = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    up_idle(); m_ok();
    s0_bus.hwdata = '0; s1_bus.hwdata = '0;
    s0_bus.hburst = 3'd0; s0_bus.hmastlock = 1'b0;
    s1_bus.hburst = 3'd0; s1_bus.hmastlock = 1'b0;
    cyc(); cyc();
    settle();
    checks++; if (m_bus.htrans !== 2'b00) begin failures++; $display("FAIL rst_m_htrans got=%h exp=0", m_bus.htrans); end
    checks++; if ({s1_bus.hready, s0_bus.hready} !== 2'b11) begin failures++; $display("FAIL rst_hready got=%b exp=11", {s1_bus.hready, s0_bus.hready}); end
    checks++; if ({s1_bus.hresp, s0_bus.hresp, s1_bus.hexokay, s0_bus.hexokay} !== 4'b0000) begin failures++; $display("FAIL rst_resp_exokay got=%b exp=0000", {s1_bus.hresp, s0_bus.hresp, s1_bus.hexokay, s0_bus.hexokay}); end
    checks++; if ({dbg_buf_vld, dbg_dph_own} !== 4'b0000) begin failures++; $display("FAIL rst_state got=%b exp=0000", {dbg_buf_vld, dbg_dph_own}); end
    checks++; if ({m_bus.hburst, m_bus.hmastlock} !== 4'b0000) begin failures++; $display("FAIL rst_burst_lock got=%b exp=0000", {m_bus.hburst, m_bus.hmastlock}); end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_single_read();
    req0(32'h100, 1'b0, 1'b0);
    settle();
    checks++; if (m_bus.htrans !== 2'b10) begin failures++; $display("FAIL rd_htrans got=%h exp=2", m_bus.htrans); end
    checks++; if (m_bus.haddr !== 32'h100) begin failures++; $display("FAIL rd_haddr got=%h exp=100", m_bus.haddr); end
    cyc();
    up_idle();
    m_bus.hrdata = 32'hDEADBEEF;
    settle();
    checks++; if (s0_bus.hrdata !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_hrdata got=%h exp=deadbeef", s0_bus.hrdata); end
    checks++; if ({s0_bus.hready, s1_bus.hresp, m_bus.htrans} !== 4'b1000) begin failures++; $display("FAIL rd_dphase got=%b exp=1000", {s0_bus.hready, s1_bus.hresp, m_bus.htrans}); end
    checks++; if (dbg_dph_own !== 2'd1) begin failures++; $display("FAIL rd_owner got=%0d exp=1", dbg_dph_own); end
    cyc();
    m_ok();
  endtask

  task automatic test_contention();
    req0(32'h200, 1'b0, 1'b0);
    req1(32'h300);
    settle();
    checks++; if ({m_bus.htrans, m_bus.haddr} !== {2'b10, 32'h200}) begin failures++; $display("FAIL ct_first got=%h exp=2_00000200", {m_bus.htrans, m_bus.haddr}); end
    cyc();
    up_idle();
    settle();
    checks++; if (dbg_buf_vld !== 2'b10) begin failures++; $display("FAIL ct_buf_vld got=%b exp=10", dbg_buf_vld); end
    checks++; if (s1_bus.hready !== 1'b0) begin failures++; $display("FAIL ct_s1_stall got=%b exp=0", s1_bus.hready); end
    checks++; if ({m_bus.htrans, m_bus.haddr} !== {2'b10, 32'h300}) begin failures++; $display("FAIL ct_replay got=%h exp=2_00000300", {m_bus.htrans, m_bus.haddr}); end
    cyc();
    m_bus.hrdata = 32'h0000_3300;
    settle();
    checks++; if ({s1_bus.hready, dbg_buf_vld, dbg_dph_own, m_bus.htrans} !== 7'b1_00_10_00) begin failures++; $display("FAIL ct_done got=%b exp=1001000", {s1_bus.hready, dbg_buf_vld, dbg_dph_own, m_bus.htrans}); end
    checks++; if (s1_bus.hrdata !== 32'h0000_3300) begin failures++; $display("FAIL ct_s1_rdata got=%h exp=00003300", s1_bus.hrdata); end
    cyc();
    m_ok();
  endtask

  task automatic test_stall_buf1();
    req0(32'h400, 1'b0, 1'b0);
    req1(32'h500);
    cyc();
    up_idle();
    m_bus.hready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++; if ({m_bus.htrans, m_bus.haddr} !== {2'b10, 32'h500}) begin failures++; $display("FAIL st_hold%0d got=%h exp=2_00000500", i, {m_bus.htrans, m_bus.haddr}); end
      checks++; if ({s0_bus.hready, s1_bus.hready} !== 2'b00) begin failures++; $display("FAIL st_rdy%0d got=%b exp=00", i, {s0_bus.hready, s1_bus.hready}); end
      cyc();
    end
    m_bus.hready = 1'b1;
    req0(32'h600, 1'b0, 1'b0);
    settle();
    checks++; if ({s0_bus.hready, m_bus.haddr} !== {1'b1, 32'h500}) begin failures++; $display("FAIL st_release got=%h exp=1_00000500", {s0_bus.hready, m_bus.haddr}); end
    cyc();
    up_idle();
    settle();
    checks++; if ({dbg_buf_vld, dbg_dph_own, s0_bus.hready} !== 5'b01_10_0) begin failures++; $display("FAIL st_s0_buf got=%b exp=01100", {dbg_buf_vld, dbg_dph_own, s0_bus.hready}); end
    checks++; if ({m_bus.htrans, m_bus.haddr} !== {2'b10, 32'h600}) begin failures++; $display("FAIL st_s0_grant got=%h exp=2_00000600", {m_bus.htrans, m_bus.haddr}); end
    cyc();
    settle();
    checks++; if ({dbg_buf_vld, dbg_dph_own, s0_bus.hready, m_bus.htrans} !== 7'b00_01_1_00) begin failures++; $display("FAIL st_end got=%b exp=0001100", {dbg_buf_vld, dbg_dph_own, s0_bus.hready, m_bus.htrans}); end
    cyc();
  endtask

  task automatic test_error();
    req0(32'h800, 1'b1, 1'b0);
    req1(32'h900);
    cyc();
    up_idle();
    s0_bus.hwdata = 32'hCAFE0001;
    m_bus.hresp = 1'b1;
    m_bus.hready = 1'b0;
    settle();
    checks++; if (m_bus.hwdata !== 32'hCAFE0001) begin failures++; $display("FAIL er_hwdata got=%h exp=cafe0001", m_bus.hwdata); end
    checks++; if ({s0_bus.hresp, s0_bus.hready, s1_bus.hresp, s1_bus.hready} !== 4'b1000) begin failures++; $display("FAIL er_cycle1 got=%b exp=1000", {s0_bus.hresp, s0_bus.hready, s1_bus.hresp, s1_bus.hready}); end
    cyc();
    m_bus.hready = 1'b1;
    settle();
    checks++; if ({s0_bus.hresp, s0_bus.hready, s1_bus.hresp} !== 3'b110) begin failures++; $display("FAIL er_cycle2 got=%b exp=110", {s0_bus.hresp, s0_bus.hready, s1_bus.hresp}); end
    checks++; if ({m_bus.htrans, m_bus.haddr} !== {2'b10, 32'h900}) begin failures++; $display("FAIL er_s1_issue got=%h exp=2_00000900", {m_bus.htrans, m_bus.haddr}); end
    cyc();
    m_bus.hresp = 1'b0;
    s0_bus.hwdata = '0;
    settle();
    checks++; if ({dbg_dph_own, dbg_buf_vld, s1_bus.hready, s1_bus.hresp, s0_bus.hresp} !== 7'b10_00_1_00) begin failures++; $display("FAIL er_after got=%b exp=1000100", {dbg_dph_own, dbg_buf_vld, s1_bus.hready, s1_bus.hresp, s0_bus.hresp}); end
    cyc();
  endtask

  task automatic test_exclusive();
    req0(32'hA00, 1'b0, 1'b1);
    settle();
    checks++; if ({m_bus.hexcl, m_bus.haddr} !== {1'b1, 32'hA00}) begin failures++; $display("FAIL ex_aph got=%h exp=1_00000a00", {m_bus.hexcl, m_bus.haddr}); end
    cyc();
    up_idle();
    m_bus.hexokay = 1'b1;
    settle();
    checks++; if ({s0_bus.hexokay, s1_bus.hexokay} !== 2'b10) begin failures++; $display("FAIL ex_okay got=%b exp=10", {s0_bus.hexokay, s1_bus.hexokay}); end
    cyc();
    m_ok();
  endtask

  task automatic test_back_to_back();
    req0(32'hD00, 1'b0, 1'b0);
    req1(32'hE00);
    cyc();
    s1_bus.htrans = 2'b00;
    for (int i = 1; i < 3; i++) begin
      req0(32'hD00 + 32'(4 * i), 1'b0, 1'b0);
      settle();
      checks++; if ({m_bus.haddr, s1_bus.hready} !== {32'hD00 + 32'(4 * i), 1'b0}) begin failures++; $display("FAIL bb_starve%0d got=%h exp=%h", i, {m_bus.haddr, s1_bus.hready}, {32'hD00 + 32'(4 * i), 1'b0}); end
      cyc();
    end
    up_idle();
    settle();
    checks++; if ({m_bus.htrans, m_bus.haddr} !== {2'b10, 32'hE00}) begin failures++; $display("FAIL bb_s1_issue got=%h exp=2_00000e00", {m_bus.htrans, m_bus.haddr}); end
    cyc();
    settle();
    checks++; if ({dbg_dph_own, s1_bus.hready} !== 3'b10_1) begin failures++; $display("FAIL bb_s1_done got=%b exp=101", {dbg_dph_own, s1_bus.hready}); end
    cyc();
  endtask

  task automatic test_reset_mid();
    req0(32'hB00, 1'b0, 1'b0);
    req1(32'hC00);
    cyc();
    up_idle();
    m_bus.hready = 1'b0;
    settle();
    checks++; if ({dbg_buf_vld, dbg_dph_own} !== 4'b10_01) begin failures++; $display("FAIL rm_before got=%b exp=1001", {dbg_buf_vld, dbg_dph_own}); end
    rst = 1'b1;
    cyc();
    settle();
    checks++; if (m_bus.htrans !== 2'b00) begin failures++; $display("FAIL rm_htrans got=%h exp=0", m_bus.htrans); end
    checks++; if ({s0_bus.hready, s1_bus.hready, dbg_buf_vld, dbg_dph_own} !== 6'b11_00_00) begin failures++; $display("FAIL rm_state got=%b exp=110000", {s0_bus.hready, s1_bus.hready, dbg_buf_vld, dbg_dph_own}); end
    rst = 1'b0;
    m_ok();
    cyc();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single_read();
    test_contention();
    test_stall_buf1();
    test_error();
    test_exclusive();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
